// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master.
// Contents: parameter defaults, the controller state enum, the response
// status codes, and a helper that sizes the timeout counter.
package wb_host_pkg;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_ADR_W   = 5;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ERROR   = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  // Counter width that can hold TIMEOUT-1. A minimum of one bit is kept
  // so that a degenerate TIMEOUT of 1 still elaborates.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog counter.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   clear  - synchronous clear to 0 (has priority over enable)
//   enable - count up by one per cycle
//   tc     - terminal count: the count equals TIMEOUT-1
module wb_timeout_counter
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Single-transaction Wishbone host master.
// A host request is latched into the Wishbone outputs. The bus cycle runs
// until the slave signals error or ack, or until the watchdog expires. The
// result is then offered on the response port until the host takes it.
// Ports:
//   clock, reset                       - clock; asynchronous active-low reset
//   req_valid/req_ready/req_we/req_adr/req_data - host request channel
//   strobe_o/we_o/adr_o/wb_data_o      - Wishbone master outputs
//   wb_data_i/ack_i/error_i            - Wishbone slave returns
//   rsp_valid/rsp_ready/rsp_data/rsp_status     - host response channel
//   busy                               - high whenever the state is not IDLE
//
// Handshake rule for both host channels: a transfer happens on a rising
// edge where valid and ready are both 1. A producer holds valid and its
// payload until that edge. The request side is ready only in IDLE. The
// response side keeps rsp_valid and its payload steady until rsp_ready.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADR_W   = DEF_ADR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [DATA_W-1:0] req_data,
  output logic              strobe_o,
  output logic              we_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ack_i,
  input  logic              error_i,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  state_t state;
  logic   tc;

  // The counter is held at 0 everywhere except BUS. This means it always
  // enters BUS at 0, and the first BUS cycle is cycle 0.
  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != BUS),
    .enable (state == BUS),
    .tc     (tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      strobe_o   <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      wb_data_o  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= STATUS_OK;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= BUS;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            strobe_o  <= 1'b1;
            we_o      <= req_we;
            adr_o     <= req_adr;
            wb_data_o <= req_data;
          end
        end
        BUS: begin
          // Termination priority: error beats ack, and ack beats timeout.
          // This lets an ack on the terminal-count edge still complete OK.
          if (error_i || ack_i || tc) begin
            state     <= RESP;
            strobe_o  <= 1'b0;
            we_o      <= 1'b0;
            rsp_valid <= 1'b1;
            if (error_i) begin
              rsp_status <= STATUS_ERROR;
              rsp_data   <= '0;
            end else if (ack_i) begin
              rsp_status <= STATUS_OK;
              rsp_data   <= we_o ? '0 : wb_data_i;
            end else begin
              rsp_status <= STATUS_TIMEOUT;
              rsp_data   <= '0;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          strobe_o  <= 1'b0;
          we_o      <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
module tb_wb_host_master;

  localparam int DATA_W  = 128;
  localparam int ADR_W   = 5;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADR_W-1:0]  req_adr;
  logic [DATA_W-1:0] req_data;
  logic              strobe_o;
  logic              we_o;
  logic [ADR_W-1:0]  adr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [DATA_W-1:0] wb_data_i;
  logic              ack_i;
  logic              error_i;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;
  logic              busy;

  wb_host_master #(.DATA_W(DATA_W), .ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_adr    (req_adr),
    .req_data   (req_data),
    .strobe_o   (strobe_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .wb_data_o  (wb_data_o),
    .wb_data_i  (wb_data_i),
    .ack_i      (ack_i),
    .error_i    (error_i),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                ack_cyc;     // strobe cycle (1-based) carrying ack, 0 = none
    int                err_cyc;     // strobe cycle (1-based) carrying error, 0 = none
    int                exp_cycles;  // expected number of strobe cycles
    logic [1:0]        exp_status;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t              vecs[8];
  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W+1:0] mon_e;
  int                checks = 0;
  int                errors = 0;

  task automatic check_w(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Reference model for random transactions. The earliest event decides
  // the outcome: error wins over ack, and the watchdog ends at TIMEOUT.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   term;
    r    = v;
    term = TIMEOUT;
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (v.err_cyc == i || v.ack_cyc == i) begin
        term = i;
        break;
      end
    end
    r.exp_cycles = term;
    if (v.err_cyc == term)      r.exp_status = 2'b01;
    else if (v.ack_cyc == term) r.exp_status = 2'b00;
    else                        r.exp_status = 2'b10;
    r.exp_data = (r.exp_status == 2'b00 && !v.we) ? v.rdata : '0;
    return r;
  endfunction

  // Response monitor: compares each consumed response with the oldest entry.
  always @(negedge clock) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got status %0h data %0h exp none", rsp_status, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check_w("rsp_status", DATA_W'(rsp_status), DATA_W'(mon_e[DATA_W+1:DATA_W]));
        check_w("rsp_data", rsp_data, mon_e[DATA_W-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left just after a rising edge. A nonzero hold keeps
  // rsp_ready low (and req_valid high) for that many cycles in RESP.
  task automatic run_txn(input vec_t v, input int hold);
    int                cyc;
    int                waitc;
    logic [DATA_W-1:0] held;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we    = v.we;
    req_adr   = v.adr;
    req_data  = v.wdata;
    wb_data_i = v.rdata;
    waitc     = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    check_bit("req_ready_before_accept", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_valid = (hold > 0);
    exp_q.push_back({v.exp_status, v.exp_data});
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (strobe_o !== 1'b1) break;
      check_bit("we_o", we_o, v.we);
      check_w("adr_o", DATA_W'(adr_o), DATA_W'(v.adr));
      check_w("wb_data_o", wb_data_o, v.wdata);
      check_bit("req_ready_bus", req_ready, 1'b0);
      ack_i   = (v.ack_cyc == i + 1);
      error_i = (v.err_cyc == i + 1);
      @(posedge clock);
      #1;
      ack_i   = 1'b0;
      error_i = 1'b0;
      cyc++;
    end
    check_int("strobe_cycles", cyc, v.exp_cycles);
    check_bit("rsp_valid_rise", rsp_valid, 1'b1);
    check_bit("we_o_outside_bus", we_o, 1'b0);
    check_w("adr_o_hold", DATA_W'(adr_o), DATA_W'(v.adr));
    if (hold > 0) begin
      held = rsp_data;
      for (int k = 0; k < hold; k++) begin
        @(posedge clock);
        @(negedge clock);
        check_bit("bp_rsp_valid", rsp_valid, 1'b1);
        check_w("bp_rsp_data", rsp_data, held);
        check_bit("bp_req_ready", req_ready, 1'b0);
        check_bit("bp_strobe", strobe_o, 1'b0);
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clock);
    end
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_bit("idle_busy", busy, 1'b0);
    check_bit("idle_req_ready", req_ready, 1'b1);
    check_bit("idle_rsp_valid", rsp_valid, 1'b0);
    @(posedge clock);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t rv;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_data  = '0;
    wb_data_i = '0;
    ack_i     = 1'b0;
    error_i   = 1'b0;
    rsp_ready = 1'b1;

    //           we    adr    wdata          rdata              ack err cyc status data
    vecs[0] = '{1'b1, 5'h04, 128'hA5,       128'hDEADBEEF,      3,  0,  3, 2'b00, 128'h0};
    vecs[1] = '{1'b0, 5'h10, 128'h0,        128'hDEADBEEF,      1,  0,  1, 2'b00, 128'hDEADBEEF};
    vecs[2] = '{1'b0, 5'h03, 128'h0,        128'h1111,          0,  0, 16, 2'b10, 128'h0};
    vecs[3] = '{1'b0, 5'h07, 128'h0,        128'h1234,          2,  2,  2, 2'b01, 128'h0};
    vecs[4] = '{1'b0, 5'h1F, 128'h0,        128'hCAFE,         16,  0, 16, 2'b00, 128'hCAFE};
    vecs[5] = '{1'b1, 5'h00, 128'h5A5A,     128'h0,             0,  1,  1, 2'b01, 128'h0};
    vecs[6] = '{1'b0, 5'h0A, 128'h0,        128'hBEEF,         17,  0, 16, 2'b10, 128'h0};
    vecs[7] = '{1'b0, 5'h15, 128'h0,        128'hFF,            0,  5,  5, 2'b01, 128'h0};

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_bit("rst_strobe", strobe_o, 1'b0);
    check_bit("rst_we", we_o, 1'b0);
    check_bit("rst_rsp_valid", rsp_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_w("rst_adr", DATA_W'(adr_o), '0);
    check_w("rst_wb_data", wb_data_o, '0);
    check_w("rst_rsp_data", rsp_data, '0);
    check_w("rst_rsp_status", DATA_W'(rsp_status), '0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) run_txn(vecs[i], 0);

    // Random transactions checked against the model.
    for (int i = 0; i < 6; i++) begin
      rv.we      = 1'($urandom_range(0, 1));
      rv.adr     = ADR_W'($urandom_range(0, 31));
      rv.wdata   = {$urandom, $urandom, $urandom, $urandom};
      rv.rdata   = {$urandom, $urandom, $urandom, $urandom};
      rv.ack_cyc = int'($urandom_range(0, 18));
      rv.err_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 0;
      run_txn(model(rv), 0);
    end

    // Backpressure: response held for 5 cycles while the host keeps requesting.
    rv = '{1'b0, 5'h02, 128'h0, 128'h77, 1, 0, 1, 2'b00, 128'h77};
    run_txn(rv, 5);

    // Reset in the second BUS cycle: the transaction is dropped silently.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = 5'h09;
    req_data  = 128'h55;
    @(negedge clock);
    check_bit("mid_req_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #2;
    check_bit("mid_strobe_before", strobe_o, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("mid_strobe_async", strobe_o, 1'b0);
    check_bit("mid_rsp_valid_async", rsp_valid, 1'b0);
    check_bit("mid_busy_async", busy, 1'b0);
    check_bit("mid_we_async", we_o, 1'b0);
    check_w("mid_adr_async", DATA_W'(adr_o), '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_bit("post_rst_rsp_valid", rsp_valid, 1'b0);
      check_bit("post_rst_req_ready", req_ready, 1'b1);
      check_bit("post_rst_strobe", strobe_o, 1'b0);
    end
    @(posedge clock);
    #1;

    // The design still works after the reset.
    run_txn(vecs[1], 0);

    check_int("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
